bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment driver and produces its 16-bit packed BCD input. It accepts a binary value through a valid/ready handshake and converts it with iterative shift-add-3 (double dabble), one bit per clock. It holds the last result stable for the display refresh logic. It runs in the display clock domain; its throughput of one conversion per BIN_W+1 cycles is adequate there.

---
 rtl/bin_to_bcd_seq.sv | 159 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter feeding the 4-digit
// seven-segment driver. Accepts an unsigned value through a valid/ready
// handshake, saturates it to MAX_VAL, and converts it with shift-add-3
// (double dabble), one bit per clock. The last result is held on
// o_bcd_data / o_overflow until the next completion or reset.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits of the completed result (thousands
//   down to tens, stopping at the first non-zero digit) are replaced by
//   4'hF, which the display driver shows as blank. Units never blank.
module bin_to_bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             r_clk_1khz,
  input  logic             i_reset,
  input  logic [BIN_W-1:0] i_bin,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [15:0]      o_bcd_data,
  output logic             o_done,
  output logic             o_overflow
);

  localparam int               CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_iter;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_work;
  logic [15:0]      bcd_work;
  logic             ovf_pend;
  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             sat;
  logic [BIN_W-1:0] bin_load;

  // Add 3 to every BCD digit that is 5 or more; digits are independent,
  // so no carry is allowed to ripple into the neighbouring nibble.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Replace leading zero digits with 4'hF; the units digit is always kept.
  function automatic logic [15:0] blank_leading(input logic [15:0] v);
    logic [15:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Final presentation of a completed result toward the display driver.
  function automatic logic [15:0] format_result(input logic [15:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    return blank_leading(v);
`else
    return v;
`endif
  endfunction

  // State register; reset returns to IDLE and aborts any conversion.
  always_ff @(posedge r_clk_1khz) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, handshake and end-of-conversion detection.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    o_ready   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          last_iter = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble iteration: adjust digits, then shift the combined
  // {bcd, bin} register left by one, pulling the binary MSB into the units.
  always_comb begin
    bcd_adj   = add3_nibbles(bcd_work);
    bcd_shift = {bcd_adj[14:0], bin_work[BIN_W-1]};
    bin_shift = {bin_work[BIN_W-2:0], 1'b0};
    sat       = (i_bin > MAX_BIN);
    bin_load  = sat ? MAX_BIN : i_bin;
  end

  // Working registers, iteration counter and held result outputs.
  always_ff @(posedge r_clk_1khz) begin
    if (i_reset) begin
      cnt        <= '0;
      bin_work   <= '0;
      bcd_work   <= '0;
      ovf_pend   <= 1'b0;
      o_bcd_data <= 16'h0000;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        bin_work <= bin_load;
        ovf_pend <= sat;
        bcd_work <= '0;
        cnt      <= CNT_LAST;
      end else if (state == SHIFT) begin
        bcd_work <= bcd_shift;
        bin_work <= bin_shift;
        cnt      <= cnt - CNT_W'(1);
        if (last_iter) begin
          o_bcd_data <= format_result(bcd_shift);
          o_overflow <= ovf_pend;
          o_done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: directed test-plan conversions with literal
// expectations, then randomized traffic (valid, values, occasional resets)
// checked every cycle against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int BIN_W   = 14;
  localparam int MAX_VAL = 9999;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [BIN_W-1:0] i_bin = '0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [15:0]      o_bcd_data;
  logic             o_done;
  logic             o_overflow;

  int vectors = 0;
  int errors  = 0;
  bit check_en = 1'b0;

  // reference model state
  bit          m_busy = 1'b0;
  int          m_left = 0;
  logic [15:0] m_pend_bcd = '0;
  bit          m_pend_ovf = 1'b0;
  logic [15:0] m_bcd = '0;
  bit          m_ovf = 1'b0;
  bit          m_done = 1'b0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
    .r_clk_1khz (clk),
    .i_reset    (rst),
    .i_bin      (i_bin),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_bcd_data (o_bcd_data),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dec_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [15:0] model_result(input int v);
    int sv;
    logic [15:0] r;
    sv = (v > MAX_VAL) ? MAX_VAL : v;
    r  = dec_bcd(sv);
`ifdef LEADING_ZERO_BLANK_EN
    if (sv < 1000) r[15:12] = 4'hF;
    if (sv < 100)  r[11:8]  = 4'hF;
    if (sv < 10)   r[7:4]   = 4'hF;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: advance on every rising edge from the driven inputs
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_left = 0; m_bcd = '0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_bcd  = m_pend_bcd;
          m_ovf  = m_pend_ovf;
          m_done = 1'b1;
        end
      end else if (i_valid) begin
        m_busy     = 1'b1;
        m_left     = BIN_W;
        m_pend_bcd = model_result(int'(i_bin));
        m_pend_ovf = (int'(i_bin) > MAX_VAL);
      end
    end
  end

  // compare process: every falling edge once checking is enabled
  always @(negedge clk) begin
    if (check_en) begin
      chk("ready", 32'(o_ready), 32'(!m_busy));
      chk("done", 32'(o_done), 32'(m_done));
      chk("bcd", 32'(o_bcd_data), 32'(m_bcd));
      chk("ovf", 32'(o_overflow), 32'(m_ovf));
    end
  end

  // Accept one value and wait for its completion, then pin the literal result.
  task automatic convert(input int v, input logic [15:0] exp_plain,
                         input logic [15:0] exp_blank, input bit exp_ovf);
    bit seen;
    logic [15:0] exp;
`ifdef LEADING_ZERO_BLANK_EN
    exp = exp_blank;
`else
    exp = exp_plain;
`endif
    @(negedge clk);
    i_bin = BIN_W'(v);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk("busy_after_accept", 32'(o_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (o_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("lit_bcd", 32'(o_bcd_data), 32'(exp));
    chk("lit_ovf", 32'(o_overflow), 32'(exp_ovf));
    chk("lit_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_bcd", 32'(o_bcd_data), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);

    convert(0,     16'h0000, 16'hFFF0, 1'b0);
    convert(1234,  16'h1234, 16'h1234, 1'b0);
    convert(9999,  16'h9999, 16'h9999, 1'b0);
    convert(7,     16'h0007, 16'hFFF7, 1'b0);
    convert(10000, 16'h9999, 16'h9999, 1'b1);
    convert(42,    16'h0042, 16'hFF42, 1'b0);
    convert(16383, 16'h9999, 16'h9999, 1'b1);
    convert(40,    16'h0040, 16'hFF40, 1'b0);
    convert(305,   16'h0305, 16'hF305, 1'b0);
    convert(1005,  16'h1005, 16'h1005, 1'b0);

    // valid held high with 1111 during the busy period of 5678
    @(negedge clk);
    i_bin = BIN_W'(5678); i_valid = 1'b1;
    @(negedge clk);
    i_bin = BIN_W'(1111);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (o_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("hold_done_seen", 32'(seen), 32'd1);
    chk("hold_first", 32'(o_bcd_data), 32'h5678);
    @(negedge clk);
    i_valid = 1'b0;
    chk("hold_busy", 32'(o_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      chk("hold_between", 32'(o_bcd_data), 32'h5678);
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    chk("hold_second_seen", 32'(seen), 32'd1);
    chk("hold_second", 32'(o_bcd_data), 32'h1111);

    // reset in the middle of a conversion
    convert(99, 16'h0099, 16'hFF99, 1'b0);
    @(negedge clk);
    i_bin = BIN_W'(4321); i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; i_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    chk("abort_bcd", 32'(o_bcd_data), 32'h0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_done", 32'(o_done), 32'd0);
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_done", 32'(o_done), 32'd0);
    end
    convert(8, 16'h0008, 16'hFFF8, 1'b0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      i_valid = ($urandom_range(0, 2) != 0);
      i_bin   = ($urandom_range(0, 1) != 0) ? BIN_W'($urandom_range(0, 9999))
                                            : BIN_W'($urandom_range(0, 16383));
      rst     = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    repeat (20) @(negedge clk);
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
